// File: rtl/sram_ctrl.sv
// sram_ctrl: single-word host controller for a 2048x8 asynchronous SRAM.
// Requests are taken on a valid/ready handshake. The SRAM strobes are then
// sequenced with cycle-counted wait states. Read data comes back with a
// one-cycle response pulse. Every output, including the data-bus enable,
// is a register.
module sram_ctrl #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8,
    parameter int RD_CYC = 1,
    parameter int WP_CYC = 1,
    parameter int TA_CYC = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] sram_addr,
    inout  wire  [DATA_W-1:0] sram_data,
    output logic              sram_cs_b,
    output logic              sram_oe_b,
    output logic              sram_we_b
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_SETUP,
        S_WR_PULSE,
        S_WR_HOLD,
        S_RD_ACCESS,
        S_TURN
    } state_t;

    // A wait counter holds (N-1) on entry and leaves its state at zero.
    localparam logic [3:0] RD_LOAD = 4'(RD_CYC - 1);
    localparam logic [3:0] WP_LOAD = 4'(WP_CYC - 1);
    localparam logic [3:0] TA_LOAD = 4'(TA_CYC - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [3:0]          r_cnt;
    logic [3:0]          w_cnt_next;
    logic                r_ready;
    logic                r_cs_b;
    logic                r_oe_b;
    logic                r_we_b;
    logic                r_data_oe;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rdata;
    logic                w_accept;
    logic                w_cnt_zero;
    logic                w_rd_capture;

    assign w_accept     = req_valid & r_ready;
    assign w_cnt_zero   = (r_cnt == 4'd0);
    assign w_rd_capture = (r_state == S_RD_ACCESS) && w_cnt_zero;

    // Next-state and wait-counter logic
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = req_wr ? S_WR_SETUP : S_RD_ACCESS;
                    w_cnt_next   = req_wr ? 4'd0 : RD_LOAD;
                end
            end
            S_WR_SETUP: begin
                w_state_next = S_WR_PULSE;
                w_cnt_next   = WP_LOAD;
            end
            S_WR_PULSE: begin
                if (w_cnt_zero) begin
                    w_state_next = S_WR_HOLD;
                    w_cnt_next   = 4'd0;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            S_WR_HOLD: begin
                w_state_next = S_TURN;
                w_cnt_next   = TA_LOAD;
            end
            S_RD_ACCESS: begin
                if (w_cnt_zero) begin
                    w_state_next = S_TURN;
                    w_cnt_next   = TA_LOAD;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            S_TURN: begin
                if (w_cnt_zero) begin
                    w_state_next = S_IDLE;
                    w_cnt_next   = 4'd0;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = 4'd0;
            end
        endcase
    end

    // State register and registered outputs. The strobes are decoded from
    // the next state, so each strobe lines up with the state it belongs to.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_ready     <= 1'b0;
            r_cs_b      <= 1'b1;
            r_oe_b      <= 1'b1;
            r_we_b      <= 1'b1;
            r_data_oe   <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rsp_valid <= 1'b0;
            r_rdata     <= '0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_ready   <= (w_state_next == S_IDLE);
            r_cs_b    <= !((w_state_next == S_WR_SETUP) || (w_state_next == S_WR_PULSE) ||
                           (w_state_next == S_WR_HOLD)  || (w_state_next == S_RD_ACCESS));
            r_oe_b    <= !(w_state_next == S_RD_ACCESS);
            r_we_b    <= !(w_state_next == S_WR_PULSE);
            r_data_oe <= (w_state_next == S_WR_SETUP) || (w_state_next == S_WR_PULSE) ||
                         (w_state_next == S_WR_HOLD);
            // Address and data change only on accept, while cs_b is still high.
            if (w_accept) begin
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end
            // The edge that ends the last access cycle captures the data and
            // raises the response for the first turnaround cycle.
            r_rsp_valid <= w_rd_capture;
            if (w_rd_capture) begin
                r_rdata <= sram_data;
            end
        end
    end

    assign req_ready = r_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rdata;
    assign sram_addr = r_addr;
    assign sram_cs_b = r_cs_b;
    assign sram_oe_b = r_oe_b;
    assign sram_we_b = r_we_b;
    assign sram_data = r_data_oe ? r_wdata : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sram_ctrl.sv
// Testbench for sram_ctrl. It builds two configurations: the default timing
// (1/1/1) and WP=3, RD=2, TA=2. Each has its own SRAM behavioural model,
// a queue-based reference model, and a directed stimulus thread.
module tb_sram_ctrl;

    typedef struct packed {
        logic cs_b;
        logic oe_b;
        logic we_b;
        logic rsp;
    } step_t;

    function automatic step_t mk(input logic c, input logic o, input logic w, input logic r);
        step_t s;
        s.cs_b = c;
        s.oe_b = o;
        s.we_b = w;
        s.rsp  = r;
        return s;
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int to_err = 0;

    for (genvar gi = 0; gi < 2; gi++) begin : cfg
        localparam int WP = (gi == 0) ? 1 : 3;
        localparam int RD = (gi == 0) ? 1 : 2;
        localparam int TA = (gi == 0) ? 1 : 2;
        // Hand-computed cycle offsets from the accept edge
        localparam int LAT_WR  = (gi == 0) ? 5 : 8;
        localparam int LAT_RD  = (gi == 0) ? 3 : 5;
        localparam int LAT_RSP = (gi == 0) ? 2 : 3;
        localparam int LIT_WE  = (gi == 0) ? 1 : 3;
        localparam int LIT_CSW = (gi == 0) ? 3 : 5;
        localparam int LIT_CSR = (gi == 0) ? 1 : 2;

        logic        rst;
        logic        req_valid;
        logic        req_wr;
        logic [10:0] req_addr;
        logic [7:0]  req_wdata;
        wire         req_ready;
        wire         rsp_valid;
        wire  [7:0]  rsp_rdata;
        wire  [10:0] sram_addr;
        wire  [7:0]  sram_data;
        wire         sram_cs_b;
        wire         sram_oe_b;
        wire         sram_we_b;

        sram_ctrl #(
            .ADDR_W(11), .DATA_W(8), .RD_CYC(RD), .WP_CYC(WP), .TA_CYC(TA)
        ) dut (
            .clk(clk), .rst(rst),
            .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
            .req_addr(req_addr), .req_wdata(req_wdata),
            .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
            .sram_addr(sram_addr), .sram_data(sram_data),
            .sram_cs_b(sram_cs_b), .sram_oe_b(sram_oe_b), .sram_we_b(sram_we_b)
        );

        // SRAM behavioural model: drives the bus when selected with oe low, and
        // stores bus data at each clock edge that sees cs and we both low.
        logic [7:0] sram_mem [0:2047];
        assign sram_data = (!sram_cs_b && !sram_oe_b) ? sram_mem[sram_addr] : 8'hzz;
        always @(posedge clk) begin
            if (!sram_cs_b && !sram_we_b) sram_mem[sram_addr] <= sram_data;
        end

        // Reference model. An accepted request expands into its per-cycle
        // strobe schedule, and one entry is retired each cycle.
        step_t       q[$];
        step_t       m_cur;
        logic        m_busy;
        logic        m_after_rst;
        logic        m_acc;
        logic [10:0] m_addr;
        logic [7:0]  m_rdata;
        logic [7:0]  ref_mem [0:2047];

        always @(posedge clk) begin
            if (rst) begin
                q.delete();
                m_cur       = mk(1'b1, 1'b1, 1'b1, 1'b0);
                m_busy      = 1'b0;
                m_after_rst = 1'b1;
                m_addr      = '0;
                m_rdata     = '0;
            end else begin
                m_acc       = !m_busy && !m_after_rst && req_valid;
                m_after_rst = 1'b0;
                if (m_acc) begin
                    m_addr = req_addr;
                    if (req_wr) begin
                        ref_mem[req_addr] = req_wdata;
                        q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0));
                        for (int i = 0; i < WP; i++) q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0));
                        q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0));
                        for (int i = 0; i < TA; i++) q.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0));
                    end else begin
                        for (int i = 0; i < RD; i++) q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0));
                        for (int i = 0; i < TA; i++) q.push_back(mk(1'b1, 1'b1, 1'b1, i == 0));
                    end
                end
                if (q.size() != 0) begin
                    m_cur  = q.pop_front();
                    m_busy = 1'b1;
                    if (m_cur.rsp) m_rdata = ref_mem[m_addr];
                end else begin
                    m_cur  = mk(1'b1, 1'b1, 1'b1, 1'b0);
                    m_busy = 1'b0;
                end
            end
        end

        int n_chk = 0;
        int n_err = 0;
        bit armed = 1'b0;
        bit done  = 1'b0;

        task automatic chk(input string name, input int act, input int exp);
            n_chk++;
            if (act != exp) begin
                n_err++;
                $display("FAIL cfg%0d %s: got %0h, expected %0h", gi, name, act, exp);
            end
        endtask

        // Per-cycle comparison of every DUT output against the model
        task automatic cmp_cycle();
            chk("req_ready", int'(req_ready), int'(!m_busy && !m_after_rst));
            chk("cs_b", int'(sram_cs_b), int'(m_cur.cs_b));
            chk("oe_b", int'(sram_oe_b), int'(m_cur.oe_b));
            chk("we_b", int'(sram_we_b), int'(m_cur.we_b));
            chk("rsp_valid", int'(rsp_valid), int'(m_cur.rsp));
            chk("rsp_rdata", int'(rsp_rdata), int'(m_rdata));
            chk("sram_addr", int'(sram_addr), int'(m_addr));
            chk("oe_we_both_low", int'(!sram_oe_b && !sram_we_b), 0);
        endtask

        task automatic tick();
            @(negedge clk);
            if (armed) cmp_cycle();
        endtask

        // One request. Latencies, strobe widths and read data are checked
        // against hand-computed literals.
        task automatic do_req(input logic wr, input logic [10:0] a, input logic [7:0] d,
                              input logic keep, input int exp_ready, input int exp_rsp,
                              input logic [7:0] exp_data);
            int k;
            int rsp_at;
            int we_lo;
            int cs_lo;
            k = 0;
            while (!req_ready && k < 50) begin
                tick();
                k++;
            end
            chk("ready_before_req", int'(req_ready), 1);
            req_valid = 1'b1;
            req_wr    = wr;
            req_addr  = a;
            req_wdata = d;
            tick();
            if (!keep) req_valid = 1'b0;
            rsp_at = 0;
            we_lo  = 0;
            cs_lo  = 0;
            k      = 1;
            while (!req_ready && k < 40) begin
                // Changing the request fields while busy must have no effect.
                req_addr  = a ^ 11'h7FF;
                req_wdata = ~d;
                req_wr    = ~wr;
                if (rsp_valid) rsp_at = k;
                if (!sram_we_b) we_lo++;
                if (!sram_cs_b) cs_lo++;
                tick();
                k++;
            end
            if (wr) begin
                chk("wr_ready_latency", k, exp_ready);
                chk("wr_no_rsp", rsp_at, 0);
                chk("wr_we_low_cycles", we_lo, LIT_WE);
                chk("wr_cs_low_cycles", cs_lo, LIT_CSW);
            end else begin
                chk("rd_ready_latency", k, exp_ready);
                chk("rd_rsp_latency", rsp_at, exp_rsp);
                chk("rd_data", int'(rsp_rdata), int'(exp_data));
                chk("rd_we_low_cycles", we_lo, 0);
                chk("rd_cs_low_cycles", cs_lo, LIT_CSR);
            end
        endtask

        // Directed stimulus
        initial begin
            rst       = 1'b1;
            req_valid = 1'b0;
            req_wr    = 1'b0;
            req_addr  = '0;
            req_wdata = '0;
            @(negedge clk);
            armed = 1'b1;
            tick();
            chk("reset_ready", int'(req_ready), 0);
            chk("reset_cs_b", int'(sram_cs_b), 1);
            chk("reset_rdata", int'(rsp_rdata), 0);
            rst = 1'b0;
            tick();

            do_req(1'b1, 11'h123, 8'hA5, 1'b0, LAT_WR, 0, 8'h00);
            do_req(1'b0, 11'h123, 8'h00, 1'b0, LAT_RD, LAT_RSP, 8'hA5);

            do_req(1'b1, 11'h000, 8'h01, 1'b0, LAT_WR, 0, 8'h00);
            do_req(1'b1, 11'h7FF, 8'hFE, 1'b0, LAT_WR, 0, 8'h00);
            do_req(1'b0, 11'h000, 8'h00, 1'b1, LAT_RD, LAT_RSP, 8'h01);
            do_req(1'b0, 11'h7FF, 8'h00, 1'b0, LAT_RD, LAT_RSP, 8'hFE);

            do_req(1'b1, 11'h040, 8'h5C, 1'b0, LAT_WR, 0, 8'h00);
            do_req(1'b0, 11'h040, 8'h00, 1'b0, LAT_RD, LAT_RSP, 8'h5C);

            // Reset in the middle of a write pulse
            req_valid = 1'b1;
            req_wr    = 1'b1;
            req_addr  = 11'h010;
            req_wdata = 8'hFF;
            tick();
            req_valid = 1'b0;
            tick();
            chk("pulse_we_low", int'(sram_we_b), 0);
            rst = 1'b1;
            tick();
            chk("rst_cs_b", int'(sram_cs_b), 1);
            chk("rst_we_b", int'(sram_we_b), 1);
            chk("rst_oe_b", int'(sram_oe_b), 1);
            chk("rst_rsp_valid", int'(rsp_valid), 0);
            chk("rst_rdata_clear", int'(rsp_rdata), 0);
            rst = 1'b0;
            tick();
            chk("rst_ready_back", int'(req_ready), 1);
            do_req(1'b0, 11'h123, 8'h00, 1'b0, LAT_RD, LAT_RSP, 8'hA5);

            do_req(1'b1, 11'h002, 8'h11, 1'b0, LAT_WR, 0, 8'h00);
            do_req(1'b1, 11'h003, 8'h22, 1'b0, LAT_WR, 0, 8'h00);
            do_req(1'b1, 11'h004, 8'h33, 1'b0, LAT_WR, 0, 8'h00);
            do_req(1'b0, 11'h002, 8'h00, 1'b1, LAT_RD, LAT_RSP, 8'h11);
            do_req(1'b0, 11'h003, 8'h00, 1'b1, LAT_RD, LAT_RSP, 8'h22);
            do_req(1'b0, 11'h004, 8'h00, 1'b0, LAT_RD, LAT_RSP, 8'h33);
            repeat (3) tick();
            chk("rdata_holds", int'(rsp_rdata), 8'h33);
            done = 1'b1;
        end
    end

    // Wait for both configurations, bounded, then report
    initial begin
        for (int c = 0; c < 20000; c++) begin
            if (cfg[0].done && cfg[1].done) break;
            @(posedge clk);
        end
        if (!(cfg[0].done && cfg[1].done)) begin
            to_err++;
            $display("FAIL timeout: done flags %0d %0d, expected 1 1", cfg[0].done, cfg[1].done);
        end
        @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", cfg[0].n_chk + cfg[1].n_chk + 1,
                 cfg[0].n_err + cfg[1].n_err + to_err);
        $finish;
    end

endmodule
